// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state type and clear-counter sizing for sram_ctrl
package sram_pkg;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  // One spare bit so the sweep counter can index DEPTH = 2**addr_bits without wrapping
  function automatic int clear_cnt_bits(int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - N x DEPTH storage, one synchronous write and one read-first read port
module sram_array #(
  parameter int N         = 8,
  parameter int ADDR_BITS = 8,
  parameter int DEPTH     = 2**ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [N-1:0]         wdata,
  output logic [N-1:0]         rdata
);

  logic [N-1:0] mem [DEPTH];

  // Read samples the pre-edge contents, so a same-edge write is not seen
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - handshaked data SRAM controller with post-reset clear sweep
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int N              = 8,
  parameter int ADDR_BITS      = 8,
  parameter int DEPTH          = 2**ADDR_BITS,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SRAM_readEnable,
  input  logic                 SRAM_writeEnable,
  input  logic [ADDR_BITS-1:0] SRAM_address,
  input  logic [N-1:0]         SRAM_data_in,
  output logic [N-1:0]         SRAM_data,
  output logic                 SRAM_dataValid,
  output logic                 SRAM_ready,
  output logic                 SRAM_error
);

  localparam int CNT_W = clear_cnt_bits(ADDR_BITS);
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] clear_cnt;
  logic             zero_q;
  logic [N-1:0]     arr_rdata;

  logic                 clearing, accept, in_range, arr_we, arr_re;
  logic [ADDR_BITS-1:0] arr_addr;
  logic [N-1:0]         arr_wdata;

  assign clearing  = (state == S_CLEAR);
  assign accept    = SRAM_ready && (state == S_READY);
  assign in_range  = {1'b0, SRAM_address} < DEPTH_L;
  assign arr_we    = clearing || (accept && SRAM_writeEnable && in_range);
  assign arr_re    = accept && SRAM_readEnable && in_range;
  assign arr_addr  = clearing ? clear_cnt[ADDR_BITS-1:0] : SRAM_address;
  assign arr_wdata = clearing ? '0 : SRAM_data_in;

  sram_array #(.N(N), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // zero_q masks the array register after reset and after an out-of-range read
  assign SRAM_data = zero_q ? '0 : arr_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      clear_cnt      <= '0;
      zero_q         <= 1'b1;
      SRAM_dataValid <= 1'b0;
      SRAM_ready     <= 1'b0;
      SRAM_error     <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clear_cnt      <= clear_cnt + CNT_W'(1);
          SRAM_dataValid <= 1'b0;
          SRAM_error     <= 1'b0;
          if (clear_cnt == DEPTH_L - CNT_W'(1)) begin
            state      <= S_READY;
            SRAM_ready <= 1'b1;
          end
        end
        S_READY: begin
          SRAM_ready     <= 1'b1;
          SRAM_dataValid <= accept && SRAM_readEnable;
          SRAM_error     <= accept && (SRAM_readEnable || SRAM_writeEnable) && !in_range;
          if (accept && SRAM_readEnable) zero_q <= !in_range;
        end
        default: state <= S_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed bench for sram_ctrl (N=8, ADDR_BITS=4, DEPTH=12)
module tb_sram_ctrl;

  localparam int N = 8;
  localparam int AB = 4;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          re, we;
  logic [AB-1:0] addr;
  logic [N-1:0]  din;
  logic [N-1:0]  data;
  logic          valid, ready, err;

  int compared = 0;
  int mismatched = 0;

  sram_ctrl #(.N(N), .ADDR_BITS(AB), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .SRAM_readEnable  (re),
    .SRAM_writeEnable (we),
    .SRAM_address     (addr),
    .SRAM_data_in     (din),
    .SRAM_data        (data),
    .SRAM_dataValid   (valid),
    .SRAM_ready       (ready),
    .SRAM_error       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [AB-1:0] a, input logic [N-1:0] d);
    re = r; we = w; addr = a; din = d;
  endtask

  task automatic sweep_and_check(input string tag);
    int bad_req = 0;
    drive(1'b1, 1'b1, 4'd2, 8'h77);
    for (int e = 1; e <= DEPTH; e++) begin
      step();
      if (e == DEPTH - 1) check({tag, "_ready_before_end"}, {31'd0, ready}, 32'd0);
      if (valid || err) bad_req++;
    end
    check({tag, "_ready_after_sweep"}, {31'd0, ready}, 32'd1);
    check({tag, "_no_pulses_during_sweep"}, bad_req, 0);
    drive(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_error", {31'd0, err}, 32'd0);
    step();
    step();
    rst = 1'b0;
    sweep_and_check("clear1");

    // Back-to-back reads of the whole array, including addr 2 hit during the sweep
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, AB'(i), '0);
      step();
      check($sformatf("clear_rd%0d_data", i), {24'd0, data}, 32'd0);
      check($sformatf("clear_rd%0d_valid", i), {31'd0, valid}, 32'd1);
    end

    drive(1'b0, 1'b1, 4'd3, 8'hA5);
    step();
    check("wr3_valid", {31'd0, valid}, 32'd0);
    check("wr3_error", {31'd0, err}, 32'd0);
    drive(1'b1, 1'b0, 4'd3, '0);
    step();
    check("rd3_data", {24'd0, data}, 32'h0000_00A5);
    check("rd3_valid", {31'd0, valid}, 32'd1);

    drive(1'b0, 1'b1, 4'd5, 8'h11);
    step();
    drive(1'b1, 1'b1, 4'd5, 8'h22);
    step();
    check("rw5_old_data", {24'd0, data}, 32'h0000_0011);
    check("rw5_valid", {31'd0, valid}, 32'd1);
    drive(1'b1, 1'b0, 4'd5, '0);
    step();
    check("rd5_new_data", {24'd0, data}, 32'h0000_0022);
    drive(1'b0, 1'b0, '0, '0);
    step();
    check("idle_valid_drop", {31'd0, valid}, 32'd0);
    check("idle_data_hold", {24'd0, data}, 32'h0000_0022);

    drive(1'b0, 1'b1, 4'd13, 8'hFF);
    step();
    check("oor_wr_error", {31'd0, err}, 32'd1);
    check("oor_wr_valid", {31'd0, valid}, 32'd0);
    drive(1'b0, 1'b0, '0, '0);
    step();
    check("oor_error_pulse_end", {31'd0, err}, 32'd0);
    drive(1'b1, 1'b0, 4'd13, '0);
    step();
    check("oor_rd_data", {24'd0, data}, 32'd0);
    check("oor_rd_valid", {31'd0, valid}, 32'd1);
    check("oor_rd_error", {31'd0, err}, 32'd1);
    drive(1'b1, 1'b0, 4'd1, '0);
    step();
    check("no_alias_rd1", {24'd0, data}, 32'd0);
    check("inrange_rd_error", {31'd0, err}, 32'd0);

    // Reset during a read stream
    drive(1'b0, 1'b1, 4'd7, 8'h5A);
    step();
    drive(1'b1, 1'b0, 4'd7, '0);
    step();
    check("rd7_data", {24'd0, data}, 32'h0000_005A);
    step();
    check("rd7_b2b_valid", {31'd0, valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    step();
    rst = 1'b0;
    sweep_and_check("clear2");
    drive(1'b1, 1'b0, 4'd7, '0);
    step();
    check("rd7_after_sweep", {24'd0, data}, 32'd0);
    check("rd7_after_sweep_valid", {31'd0, valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
